// File: rtl/loader_pkg.sv
// Shared encodings for the UART program loader: FSM states and error codes.
package loader_pkg;

   typedef enum logic [2:0] {
      StCntLo,
      StCntHi,
      StData,
      StCheck,
      StDone,
      StError
   } load_state_e;

   typedef enum logic [1:0] {
      RxIdle,
      RxStart,
      RxData,
      RxStop
   } rx_state_e;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_FRAME = 2'b01;
   localparam logic [1:0] ERR_OVF   = 2'b10;
   localparam logic [1:0] ERR_CSUM  = 2'b11;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchroniser, false-start rejection, mid-bit sampling.
module uart_rx_byte
   import loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err
);

   localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
   localparam logic [TimerW-1:0] HalfBit = TimerW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TimerW-1:0] FullBit = TimerW'(CLKS_PER_BIT - 1);

   logic              rx_meta_q;
   logic              rx_sync_q;
   logic              rx_prev_q;
   rx_state_e         state_q;
   logic [TimerW-1:0] timer_q;
   logic [2:0]        bit_idx_q;
   logic [7:0]        shift_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= RxIdle;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         unique case (state_q)
            RxIdle: begin
               if (rx_prev_q && !rx_sync_q) begin
                  state_q <= RxStart;
                  timer_q <= '0;
               end
            end
            RxStart: begin
               // Line back high at mid start bit means a glitch, not a start bit.
               if (timer_q == HalfBit) begin
                  timer_q   <= '0;
                  bit_idx_q <= '0;
                  state_q   <= rx_sync_q ? RxIdle : RxData;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            RxData: begin
               if (timer_q == FullBit) begin
                  timer_q   <= '0;
                  shift_q   <= {rx_sync_q, shift_q[7:1]};
                  bit_idx_q <= bit_idx_q + 1'b1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= RxStop;
                  end
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            RxStop: begin
               if (timer_q == FullBit) begin
                  timer_q <= '0;
                  state_q <= RxIdle;
                  if (rx_sync_q) begin
                     valid <= 1'b1;
                     data  <= shift_q;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            default: state_q <= RxIdle;
         endcase
      end
   end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a checksummed program image from UART into instruction memory and
// holds the core until the image is complete and verified.
module uart_program_loader
   import loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned ADDR_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              uart_rx,
   input  logic              load_req,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic [1:0]        err_code
);

   localparam logic [16:0] MaxWords = 17'(2 ** ADDR_W);

   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_frame_err;

   load_state_e       state_q;
   logic [ADDR_W-1:0] next_addr_q;
   logic [15:0]       count_q;
   logic [23:0]       word_q;
   logic [1:0]        byte_idx_q;
   logic [7:0]        sum_q;

   logic [15:0]       count_full;
   logic              receiving;
   logic              last_word;

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx       (uart_rx),
      .data     (rx_data),
      .valid    (rx_valid),
      .frame_err(rx_frame_err)
   );

   always_comb begin
      count_full = {rx_data, count_q[7:0]};
      receiving  = (state_q == StCntLo) || (state_q == StCntHi) ||
                   (state_q == StData)  || (state_q == StCheck);
      last_word  = (16'(next_addr_q) == count_q - 16'd1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StCntLo;
         next_addr_q <= '0;
         count_q     <= '0;
         word_q      <= '0;
         byte_idx_q  <= '0;
         sum_q       <= '0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         core_hold   <= 1'b1;
         done        <= 1'b0;
         err_code    <= ERR_NONE;
      end else begin
         imem_we <= 1'b0;
         // A restart takes priority over any byte landing in the same cycle.
         if (load_req && (state_q == StDone || state_q == StError)) begin
            state_q     <= StCntLo;
            next_addr_q <= '0;
            imem_addr   <= '0;
            byte_idx_q  <= '0;
            sum_q       <= '0;
            core_hold   <= 1'b1;
            done        <= 1'b0;
            err_code    <= ERR_NONE;
         end else if (rx_frame_err && receiving) begin
            state_q  <= StError;
            err_code <= ERR_FRAME;
         end else if (rx_valid) begin
            unique case (state_q)
               StCntLo: begin
                  count_q[7:0] <= rx_data;
                  state_q      <= StCntHi;
               end
               StCntHi: begin
                  count_q <= count_full;
                  if ({1'b0, count_full} > MaxWords) begin
                     state_q  <= StError;
                     err_code <= ERR_OVF;
                  end else if (count_full == 16'd0) begin
                     state_q <= StCheck;
                  end else begin
                     state_q <= StData;
                  end
               end
               StData: begin
                  sum_q      <= sum_q + rx_data;
                  byte_idx_q <= byte_idx_q + 1'b1;
                  case (byte_idx_q)
                     2'd0: word_q[7:0]   <= rx_data;
                     2'd1: word_q[15:8]  <= rx_data;
                     2'd2: word_q[23:16] <= rx_data;
                     default: begin
                        imem_we     <= 1'b1;
                        imem_addr   <= next_addr_q;
                        imem_wdata  <= {rx_data, word_q};
                        next_addr_q <= next_addr_q + 1'b1;
                        if (last_word) begin
                           state_q <= StCheck;
                        end
                     end
                  endcase
               end
               StCheck: begin
                  if (rx_data == sum_q) begin
                     state_q   <= StDone;
                     done      <= 1'b1;
                     core_hold <= 1'b0;
                  end else begin
                     state_q  <= StError;
                     err_code <= ERR_CSUM;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: table vectors, corner sequences, random frames.
module tb_uart_program_loader;

   localparam int CPB = 8;
   localparam int AW  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          uart_rx = 1'b1;
   logic          load_req = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_hold;
   logic          done;
   logic [1:0]    err_code;

   always #5 clk = ~clk;

   uart_program_loader #(
      .CLKS_PER_BIT(CPB),
      .ADDR_W      (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .uart_rx   (uart_rx),
      .load_req  (load_req),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .core_hold (core_hold),
      .done      (done),
      .err_code  (err_code)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   typedef struct {
      int               n;
      logic [3:0][31:0] w;
      bit               csum_force;
      logic [7:0]       csum_val;
      int               bad_stop;
      int               exp_writes;
      bit               exp_done;
      logic [1:0]       exp_err;
   } vec_t;

   int   total = 0;
   int   bad = 0;
   wr_t  wq[$];
   int   we_double = 0;
   int   inv_bad = 0;
   logic we_prev = 1'b0;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wq.push_back('{addr: imem_addr, data: imem_wdata});
         if (we_prev) we_double++;
      end
      we_prev = (imem_we === 1'b1);
      if (rst_n && (done !== ~core_hold)) inv_bad++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic restart(input string tag);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      check({tag, " hold after load_req"}, core_hold, 1);
      check({tag, " done after load_req"}, done, 0);
      check({tag, " err after load_req"}, err_code, 0);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [7:0] bytes[$];
      logic [7:0] s;
      logic [7:0] b;
      logic [15:0] n16;
      s = 8'd0;
      n16 = v.n[15:0];
      wq.delete();
      bytes.push_back(n16[7:0]);
      bytes.push_back(n16[15:8]);
      if (v.n <= 4) begin
         for (int k = 0; k < v.n; k++) begin
            for (int j = 0; j < 4; j++) begin
               b = v.w[k][8*j +: 8];
               bytes.push_back(b);
               s = s + b;
            end
         end
         bytes.push_back(v.csum_force ? v.csum_val : s);
      end
      for (int i = 0; i < bytes.size(); i++) begin
         send_byte(bytes[i], i != v.bad_stop);
         if (i == v.bad_stop) break;
      end
      repeat (4 * CPB) @(negedge clk);
      check({tag, " write count"}, wq.size(), v.exp_writes);
      for (int k = 0; k < v.exp_writes && k < wq.size(); k++) begin
         check({tag, " write addr"}, wq[k].addr, k);
         check({tag, " write data"}, wq[k].data, v.w[k]);
      end
      check({tag, " done"}, done, v.exp_done);
      check({tag, " err_code"}, err_code, v.exp_err);
      check({tag, " core_hold"}, core_hold, !v.exp_done);
   endtask

   // Outcome derived from the frame rules: first framing fault, then checksum.
   function automatic void model(inout vec_t v);
      logic [7:0] s;
      s = 8'd0;
      for (int k = 0; k < v.n; k++)
         s = s + v.w[k][7:0] + v.w[k][15:8] + v.w[k][23:16] + v.w[k][31:24];
      v.exp_done = 1'b0;
      if (v.bad_stop >= 0) begin
         v.exp_err    = 2'b01;
         v.exp_writes = (v.bad_stop < 2) ? 0 : (v.bad_stop - 2) / 4;
      end else if (v.csum_force && v.csum_val != s) begin
         v.exp_err    = 2'b11;
         v.exp_writes = v.n;
      end else begin
         v.exp_err    = 2'b00;
         v.exp_writes = v.n;
         v.exp_done   = 1'b1;
      end
   endfunction

   vec_t tab[6];
   vec_t rv;

   initial begin
      tab[0] = '{n: 2, w: {32'h0, 32'h0, 32'hDEADBEEF, 32'h00000013}, csum_force: 0,
                 csum_val: 8'h00, bad_stop: -1, exp_writes: 2, exp_done: 1, exp_err: 2'b00};
      tab[1] = '{n: 1, w: {32'h0, 32'h0, 32'h0, 32'h11223344}, csum_force: 1,
                 csum_val: 8'h00, bad_stop: -1, exp_writes: 1, exp_done: 0, exp_err: 2'b11};
      tab[2] = '{n: 257, w: '0, csum_force: 0,
                 csum_val: 8'h00, bad_stop: -1, exp_writes: 0, exp_done: 0, exp_err: 2'b10};
      tab[3] = '{n: 2, w: {32'h0, 32'h0, 32'h55667788, 32'h01020304}, csum_force: 0,
                 csum_val: 8'h00, bad_stop: 3, exp_writes: 0, exp_done: 0, exp_err: 2'b01};
      tab[4] = '{n: 0, w: '0, csum_force: 0,
                 csum_val: 8'h00, bad_stop: -1, exp_writes: 0, exp_done: 1, exp_err: 2'b00};
      tab[5] = '{n: 4, w: {32'hFFFFFFFF, 32'h80000001, 32'hA5A5A5A5, 32'h00000001},
                 csum_force: 0, csum_val: 8'h00, bad_stop: -1, exp_writes: 4, exp_done: 1,
                 exp_err: 2'b00};

      repeat (3) @(negedge clk);
      check("reset imem_we", imem_we, 0);
      check("reset imem_addr", imem_addr, 0);
      check("reset imem_wdata", imem_wdata, 0);
      check("reset core_hold", core_hold, 1);
      check("reset done", done, 0);
      check("reset err_code", err_code, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         if (i > 0) restart($sformatf("tab%0d", i));
         run_vec(tab[i], $sformatf("tab%0d", i));
      end

      // Short low glitch while idle must not produce a byte.
      restart("glitch");
      wq.delete();
      uart_rx = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("glitch no write", wq.size(), 0);
      check("glitch done", done, 0);
      check("glitch err", err_code, 0);
      run_vec(tab[0], "after glitch");

      // Reset in the middle of a frame, then a complete frame.
      restart("midreset");
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
      rst_n = 1'b0;
      #1;
      check("midreset imem_addr", imem_addr, 0);
      check("midreset imem_wdata", imem_wdata, 0);
      check("midreset core_hold", core_hold, 1);
      check("midreset err", err_code, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      rv = '{n: 1, w: {32'h0, 32'h0, 32'h0, 32'hCAFEBABE}, csum_force: 0, csum_val: 8'h00,
             bad_stop: -1, exp_writes: 1, exp_done: 1, exp_err: 2'b00};
      run_vec(rv, "cafebabe");
      restart("cafebabe");

      for (int r = 0; r < 10; r++) begin
         rv.n = $urandom_range(0, 3);
         for (int k = 0; k < 4; k++) rv.w[k] = $urandom;
         rv.csum_force = ($urandom_range(0, 3) == 0);
         rv.csum_val   = 8'($urandom);
         rv.bad_stop   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2 + 4 * rv.n) : -1;
         model(rv);
         run_vec(rv, $sformatf("rand%0d", r));
         restart($sformatf("rand%0d", r));
      end

      check("imem_we single-cycle", we_double, 0);
      check("done vs core_hold", inv_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
